local_predictor_param: RTL and testbench

Parametrised local-history branch predictor for the tournament predictor's local side. A Local History Table (LHT) indexed by PC feeds a Local Prediction Table (LPT) of saturating counters. Predictions come out of a 2-stage pipeline, and trained outcomes arrive on a separate update port. After reset, an internal sweep initialises both tables, so the tables need no asynchronous reset. The counter value and history are exported for the chooser.

---
 rtl/local_predictor_param.sv | 174 +++++++++++++++++
 tb/tb_local_predictor_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/local_predictor_param.sv
// Local-history branch predictor: PC-indexed history table feeding a table of saturating
// counters, 2-stage prediction pipeline, separate training port, post-reset table sweep.
module local_predictor_param #(
   parameter int PC_BITS     = 10,
   parameter int LHT_ENTRIES = 1024,
   parameter int HIST_BITS   = 10,
   parameter int CTR_BITS    = 3
) (
   input  logic                 clock,
   input  logic                 reset_n,
   output logic                 ready,
   input  logic                 pred_valid,
   input  logic [PC_BITS-1:0]   pred_pc,
   output logic                 pred_out_valid,
   output logic                 pred_taken,
   output logic [CTR_BITS-1:0]  pred_counter,
   output logic [HIST_BITS-1:0] pred_history,
   input  logic                 update_valid,
   input  logic [PC_BITS-1:0]   update_pc,
   input  logic                 update_taken
);

   localparam int IDX         = $clog2(LHT_ENTRIES);
   localparam int LPT_ENTRIES = 1 << HIST_BITS;
   localparam int SWEEP_N     = (LHT_ENTRIES > LPT_ENTRIES) ? LHT_ENTRIES : LPT_ENTRIES;
   localparam int CNT_W       = $clog2(SWEEP_N) + 1;
   localparam logic [CTR_BITS-1:0]  CINIT    = {1'b0, {(CTR_BITS-1){1'b1}}};
   localparam logic [CTR_BITS-1:0]  CMAX     = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0]  CMIN     = {CTR_BITS{1'b0}};
   localparam logic [CTR_BITS-1:0]  CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SWEEP_N - 1);
   localparam logic [HIST_BITS-1:0] HIST_ZERO = {HIST_BITS{1'b0}};

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

   logic [HIST_BITS-1:0] lht_q [LHT_ENTRIES];
   logic [CTR_BITS-1:0]  lpt_q [LPT_ENTRIES];

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 s1_valid_q, s1_valid_d;
   logic [HIST_BITS-1:0] hist_s1_q, hist_s1_d;
   logic                 out_valid_q, out_valid_d;
   logic                 taken_q, taken_d;
   logic [CTR_BITS-1:0]  ctr_q, ctr_d;
   logic [HIST_BITS-1:0] hist_q, hist_d;

   logic                 upd_fire;
   logic [IDX-1:0]       upd_idx, pred_idx;
   logic [HIST_BITS-1:0] upd_h, upd_hist_new;
   logic [CTR_BITS-1:0]  upd_ctr_old, upd_ctr_new, s2_ctr;
   logic                 lht_we, lpt_we;
   logic [IDX-1:0]       lht_waddr;
   logic [HIST_BITS-1:0] lht_wdata, lpt_waddr;
   logic [CTR_BITS-1:0]  lpt_wdata;
   logic                 unused_pc_bits;

   // Upper PC bits only alias; they are deliberately not part of the index.
   assign unused_pc_bits = ^{pred_pc, update_pc};

   // Training datapath: saturating counter step and history shift for the resolved branch.
   always_comb begin
      upd_fire     = (state_q == ST_RUN) && update_valid;
      upd_idx      = update_pc[IDX-1:0];
      upd_h        = lht_q[upd_idx];
      upd_ctr_old  = lpt_q[upd_h];
      upd_ctr_new  = upd_ctr_old;
      if (update_taken) begin
         if (upd_ctr_old == CMAX) upd_ctr_new = CMAX;
         else                     upd_ctr_new = upd_ctr_old + CTR_ONE;
      end else begin
         if (upd_ctr_old == CMIN) upd_ctr_new = CMIN;
         else                     upd_ctr_new = upd_ctr_old - CTR_ONE;
      end
      upd_hist_new = {upd_h[HIST_BITS-2:0], update_taken};
   end

   // Table write ports: the init sweep owns both tables until RUN, then training does.
   always_comb begin
      lht_we    = 1'b0;
      lht_waddr = upd_idx;
      lht_wdata = upd_hist_new;
      lpt_we    = 1'b0;
      lpt_waddr = upd_h;
      lpt_wdata = upd_ctr_new;
      if (state_q == ST_INIT) begin
         lht_we    = (cnt_q < CNT_W'(LHT_ENTRIES));
         lht_waddr = cnt_q[IDX-1:0];
         lht_wdata = HIST_ZERO;
         lpt_we    = (cnt_q < CNT_W'(LPT_ENTRIES));
         lpt_waddr = cnt_q[HIST_BITS-1:0];
         lpt_wdata = CINIT;
      end else begin
         lht_we = upd_fire;
         lpt_we = upd_fire;
      end
   end

   // Sweep FSM: one table row per clock, then RUN until the next reset.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RUN;
               cnt_d   = cnt_q;
            end else begin
               state_d = ST_INIT;
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   // Prediction pipeline; both stages forward a same-edge update so it is never missed.
   always_comb begin
      pred_idx   = pred_pc[IDX-1:0];
      s1_valid_d = (state_q == ST_RUN) && pred_valid;
      if (upd_fire && (upd_idx == pred_idx)) hist_s1_d = upd_hist_new;
      else                                   hist_s1_d = lht_q[pred_idx];
      if (upd_fire && (upd_h == hist_s1_q))  s2_ctr = upd_ctr_new;
      else                                   s2_ctr = lpt_q[hist_s1_q];
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
         ctr_d   = s2_ctr;
         hist_d  = hist_s1_q;
         taken_d = s2_ctr[CTR_BITS-1];
      end else begin
         ctr_d   = ctr_q;
         hist_d  = hist_q;
         taken_d = taken_q;
      end
   end

   // Control and output registers, cleared asynchronously.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= {CNT_W{1'b0}};
         s1_valid_q  <= 1'b0;
         hist_s1_q   <= HIST_ZERO;
         out_valid_q <= 1'b0;
         taken_q     <= 1'b0;
         ctr_q       <= CMIN;
         hist_q      <= HIST_ZERO;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         s1_valid_q  <= s1_valid_d;
         hist_s1_q   <= hist_s1_d;
         out_valid_q <= out_valid_d;
         taken_q     <= taken_d;
         ctr_q       <= ctr_d;
         hist_q      <= hist_d;
      end
   end

   // Table storage; contents are established by the sweep rather than by reset.
   always_ff @(posedge clock) begin
      if (lht_we) lht_q[lht_waddr] <= lht_wdata;
      if (lpt_we) lpt_q[lpt_waddr] <= lpt_wdata;
   end

   assign ready          = (state_q == ST_RUN);
   assign pred_out_valid = out_valid_q;
   assign pred_taken     = taken_q;
   assign pred_counter   = ctr_q;
   assign pred_history   = hist_q;

endmodule

// File: tb/tb_local_predictor_param.sv
// Randomised plus directed bench for local_predictor_param against a table-level reference
// model; a second instance exercises a small parameter set with directed checks.
module tb_local_predictor_param;

   localparam int LHT_N = 1024;
   localparam int LPT_N = 1024;
   localparam int CMAX  = 7;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset_n, ready, pred_valid, pred_out_valid, pred_taken;
   logic       update_valid, update_taken;
   logic [9:0] pred_pc, update_pc, pred_history;
   logic [2:0] pred_counter;

   logic       v_rst_n, v_ready, v_pred_valid, v_out_valid, v_taken, v_upd_valid, v_upd_taken;
   logic [9:0] v_pred_pc, v_upd_pc;
   logic [5:0] v_history;
   logic [1:0] v_counter;

   local_predictor_param dut (
      .clock(clock), .reset_n(reset_n), .ready(ready),
      .pred_valid(pred_valid), .pred_pc(pred_pc),
      .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
      .pred_counter(pred_counter), .pred_history(pred_history),
      .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken)
   );

   local_predictor_param #(.PC_BITS(10), .LHT_ENTRIES(64), .HIST_BITS(6), .CTR_BITS(2)) u_var (
      .clock(clock), .reset_n(v_rst_n), .ready(v_ready),
      .pred_valid(v_pred_valid), .pred_pc(v_pred_pc),
      .pred_out_valid(v_out_valid), .pred_taken(v_taken),
      .pred_counter(v_counter), .pred_history(v_history),
      .update_valid(v_upd_valid), .update_pc(v_upd_pc), .update_taken(v_upd_taken)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int lht_m [LHT_N];
   int lpt_m [LPT_N];
   int m_edges;
   bit m_ready, m_s1_valid, m_out_valid;
   int m_s1_hist, m_hist, m_ctr;

   task automatic check_eq(input string tag, input logic [31:0] act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < LHT_N; i++) lht_m[i] = 0;
      for (int i = 0; i < LPT_N; i++) lpt_m[i] = 3;
      m_edges = 0; m_ready = 0; m_s1_valid = 0; m_out_valid = 0;
      m_s1_hist = 0; m_hist = 0; m_ctr = 0;
   endtask

   // One rising edge as the specification describes it: update first, then both lookups.
   task automatic model_edge(input int pv, input int ppc, input int uv, input int upc, input int ut);
      bit running;
      int h;
      running = (m_edges >= LHT_N);
      if (running && uv != 0) begin
         h = lht_m[upc % LHT_N];
         if (ut != 0) lpt_m[h] = (lpt_m[h] == CMAX) ? CMAX : lpt_m[h] + 1;
         else         lpt_m[h] = (lpt_m[h] == 0) ? 0 : lpt_m[h] - 1;
         lht_m[upc % LHT_N] = (h * 2 + (ut != 0 ? 1 : 0)) % LPT_N;
      end
      m_out_valid = m_s1_valid;
      if (m_s1_valid) begin
         m_hist = m_s1_hist;
         m_ctr  = lpt_m[m_s1_hist];
      end
      m_s1_valid = running && (pv != 0);
      if (pv != 0) m_s1_hist = lht_m[ppc % LHT_N];
      if (m_edges < LHT_N) m_edges++;
      m_ready = (m_edges >= LHT_N);
   endtask

   task automatic step(input int pv, input int ppc, input int uv, input int upc, input int ut);
      pred_valid   = (pv != 0);
      pred_pc      = 10'(ppc);
      update_valid = (uv != 0);
      update_pc    = 10'(upc);
      update_taken = (ut != 0);
      @(posedge clock);
      model_edge(pv, ppc, uv, upc, ut);
      #1;
      check_eq("ready", ready, m_ready);
      check_eq("out_valid", pred_out_valid, m_out_valid);
      if (m_out_valid) begin
         check_eq("history", pred_history, m_hist);
         check_eq("counter", pred_counter, m_ctr);
         check_eq("taken", pred_taken, (m_ctr >= 4) ? 1 : 0);
      end
      pred_valid = 1'b0; update_valid = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("rst_ready", ready, 0);
      check_eq("rst_valid", pred_out_valid, 0);
      check_eq("rst_taken", pred_taken, 0);
      check_eq("rst_counter", pred_counter, 0);
      check_eq("rst_history", pred_history, 0);
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // sweep with junk traffic, which must all be dropped
   task automatic run_init();
      while (!m_ready)
         step($urandom % 2, $urandom % 1024, $urandom % 2, $urandom % 1024, $urandom % 2);
   endtask

   task automatic predict_check(input string tag, input int pc, input int hist, input int ctr);
      step(1, pc, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check_eq({tag, "_valid"}, pred_out_valid, 1);
      check_eq({tag, "_hist"}, pred_history, hist);
      check_eq({tag, "_ctr"}, pred_counter, ctr);
      check_eq({tag, "_taken"}, pred_taken, (ctr >= 4) ? 1 : 0);
   endtask

   task automatic v_cycle(input int pv, input int ppc, input int uv, input int upc, input int ut);
      v_pred_valid = (pv != 0);
      v_pred_pc    = 10'(ppc);
      v_upd_valid  = (uv != 0);
      v_upd_pc     = 10'(upc);
      v_upd_taken  = (ut != 0);
      @(posedge clock);
      #1;
      v_pred_valid = 1'b0; v_upd_valid = 1'b0;
   endtask

   task automatic v_predict(input string tag, input int pc, input int hist, input int ctr);
      v_cycle(1, pc, 0, 0, 0);
      v_cycle(0, 0, 0, 0, 0);
      check_eq({tag, "_valid"}, v_out_valid, 1);
      check_eq({tag, "_hist"}, v_history, hist);
      check_eq({tag, "_ctr"}, v_counter, ctr);
      check_eq({tag, "_taken"}, v_taken, (ctr >= 2) ? 1 : 0);
   endtask

   initial begin
      int k;
      reset_n = 1'b0; v_rst_n = 1'b0;
      pred_valid = 1'b0; pred_pc = 10'd0; update_valid = 1'b0; update_pc = 10'd0; update_taken = 1'b0;
      v_pred_valid = 1'b0; v_pred_pc = 10'd0; v_upd_valid = 1'b0; v_upd_pc = 10'd0; v_upd_taken = 1'b0;

      // fresh init and defaults
      do_reset();
      run_init();
      predict_check("init", 5, 0, 3);

      // training: three taken updates walk history 0 -> 1 -> 3 -> 7
      for (int i = 0; i < 3; i++) step(0, 0, 1, 5, 1);
      predict_check("train", 5, 7, 3);
      step(0, 0, 1, 6, 1);
      step(0, 0, 1, 6, 1);
      predict_check("train_lpt3", 6, 3, 4);

      // saturation at both ends of LPT[0]
      do_reset();
      run_init();
      for (int i = 0; i < 10; i++) step(0, 0, 1, 9, 0);
      predict_check("sat_low", 9, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 20 + i, 1);
      predict_check("sat_high", 30, 0, 7);

      // forwarding into stage 1, then into stage 2
      do_reset();
      run_init();
      step(1, 5, 1, 5, 1);
      step(0, 0, 0, 0, 0);
      check_eq("fwd1_hist", pred_history, 1);
      check_eq("fwd1_ctr", pred_counter, 3);
      step(1, 5, 0, 0, 0);
      step(0, 0, 1, 5, 0);
      check_eq("fwd2_hist", pred_history, 1);
      check_eq("fwd2_ctr", pred_counter, 2);

      // random traffic over a small PC range to force collisions
      for (int i = 0; i < 400; i++)
         step($urandom % 2, $urandom % 16, $urandom % 2, $urandom % 16, $urandom % 2);

      // reset with a prediction on the output and another in flight
      step(1, 5, 0, 0, 0);
      step(1, 5, 0, 0, 0);
      do_reset();
      run_init();
      predict_check("post_rst", 5, 0, 3);

      // small parameter set
      #1;
      check_eq("var_rst_ready", v_ready, 0);
      @(negedge clock);
      v_rst_n = 1'b1;
      k = 0;
      while (!v_ready && k < 200) begin
         @(posedge clock);
         #1;
         k++;
      end
      check_eq("var_init_edges", k, 64);
      v_predict("var_init", 5, 0, 1);
      v_cycle(0, 0, 1, 'h45, 1);
      v_predict("var_alias", 'h05, 1, 1);
      for (int i = 10; i < 16; i++) v_cycle(0, 0, 1, i, 1);
      v_predict("var_sat_high", 20, 0, 3);
      for (int i = 30; i < 36; i++) v_cycle(0, 0, 1, i, 0);
      v_predict("var_sat_low", 40, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
